fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage that produces the 32-bit instruction word and PC consumed by the ID-stage decoder.
- Keeps the architectural fetch PC and issues one request at a time to the instruction memory port.
- Hands the returned instruction to ID over a valid/ready handshake.
- Accepts a redirect (branch/jump target) from later stages and discards any stale in-flight fetch.

Parameters:
- PC_WIDTH, 64, width of the PC and memory address.
- RESET_PC, 64'h8000_0000, first fetch address after reset.

Ports:
- clk  input  1  core clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset. Sampled on the rising edge of clk; 0 = reset.
- imem_req_valid  output  1  fetch request present.
- imem_req_addr  output  PC_WIDTH  fetch address, always 4-byte aligned.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_resp_valid  input  1  instruction data returned this cycle.
- imem_resp_data  input  32  returned instruction word.
- out_valid  output  1  out_instu/out_pc valid for ID.
- out_ready  input  1  ID consumes the instruction this cycle.
- out_instu  output  32  instruction word to the decoder.
- out_pc  output  PC_WIDTH  address of out_instu.
- redirect_valid  input  1  redirect fetch this cycle.
- redirect_pc  input  PC_WIDTH  new fetch target; bits [1:0] are ignored and treated as 0.

Behaviour:
- Registers:
  - pc: next address to fetch.
  - state: REQ, WAIT or HOLD.
  - drop: discard the next response.
  - out_instu, out_pc, out_valid.
- Reset (reset==0 at a clock edge):
  - pc=RESET_PC, state=REQ, drop=0.
  - out_valid=0, out_instu=32'h0, out_pc=RESET_PC.
  - imem_req_valid=0 in every cycle where reset is 0.
  - Reset mid-operation abandons any outstanding request. A response arriving later with drop=0 is still captured, so the memory side must be reset together with this block.
- imem_req_valid = (state==REQ) && reset. imem_req_addr = pc. Both stay stable until accepted, except when a redirect changes pc.
- REQ state:
  - On the imem_req_valid && imem_req_ready handshake -> WAIT.
  - If redirect_valid in the same cycle: pc<=redirect_pc, and drop<=1 if the request was accepted.
  - If redirect_valid without acceptance: pc<=redirect_pc, stay in REQ.
- WAIT state:
  - imem_resp_valid with drop==1: discard data, drop<=0, -> REQ.
  - imem_resp_valid with drop==0 and no redirect: out_instu<=imem_resp_data, out_pc<=pc, out_valid<=1, pc<=pc+4, -> HOLD.
  - redirect_valid in WAIT: pc<=redirect_pc. If a response arrives in the same cycle, it is discarded and the state goes to REQ. Otherwise drop<=1 and the state stays in WAIT.
- HOLD state:
  - out_valid=1; outputs stay stable until out_valid && out_ready.
  - On the handshake: out_valid<=0, -> REQ.
  - redirect_valid in HOLD, with or without out_ready: out_valid<=0, pc<=redirect_pc, -> REQ. This is a flush; ID must ignore a handshake in a redirect cycle.
- Redirect priority: redirect_valid overrides every normal pc update in the same cycle.
- Arithmetic: pc+4 wraps modulo 2^PC_WIDTH, so all-ones-minus-3 wraps to 0.
- At most one request outstanding. Minimum throughput: one instruction per 3 cycles with zero-latency memory and out_ready held at 1.
- imem_resp_valid outside WAIT is ignored.

Test Plan:
- Reset release, memory always ready with 1-cycle response, out_ready=1 -> requests at 0x8000_0000, 0x8000_0004 and 0x8000_0008. out_instu matches the memory words with matching out_pc; out_valid stays 0 during reset.
- Backpressure: out_ready=0 for 5 cycles in HOLD -> out_valid=1 throughout, no new imem_req_valid, and out_instu/out_pc are unchanged. On release the next request is for pc+4.
- Redirect in WAIT to 0x8000_0103 with the response 3 cycles later -> that response is discarded, out_valid never goes high for it, and the next request is 0x8000_0100.
- Redirect in the same cycle as imem_resp_valid -> the data is discarded and the next request is redirect_pc with the low bits cleared.
- Redirect in HOLD with out_ready=1 -> out_valid falls next cycle and the next request is redirect_pc, not the old pc+4.
- pc=PC_WIDTH'(-4) fetched -> the next request address is 0. Assert reset=0 in WAIT -> the next cycle has out_valid=0 and imem_req_valid=0, and the first request after release is RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding the ID decoder.
//   clk, reset (sync, active-low)
//   imem_req_valid/addr/ready  : one-at-a-time fetch request to instruction memory
//   imem_resp_valid/data       : returned instruction word
//   out_valid/ready/instu/pc   : instruction and its PC handed to ID
//   redirect_valid/pc          : new fetch target from later stages; low two bits ignored
module fetch_unit #(
   parameter int PC_WIDTH = 64,
   parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(64'h8000_0000)
) (
   input  logic                clk,
   input  logic                reset,
   output logic                imem_req_valid,
   output logic [PC_WIDTH-1:0] imem_req_addr,
   input  logic                imem_req_ready,
   input  logic                imem_resp_valid,
   input  logic [31:0]         imem_resp_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [31:0]         out_instu,
   output logic [PC_WIDTH-1:0] out_pc,
   input  logic                redirect_valid,
   input  logic [PC_WIDTH-1:0] redirect_pc
);
   typedef enum logic [1:0] {REQ, WAIT, HOLD} state_t;
   state_t state, state_n;
   logic [PC_WIDTH-1:0] pc, pc_n, out_pc_n;
   logic [31:0] out_instu_n;
   logic drop, drop_n, out_valid_n;
   assign imem_req_valid = (state == REQ) && reset;
   assign imem_req_addr = pc;
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= REQ;
         pc        <= RESET_PC;
         drop      <= 1'b0;
         out_valid <= 1'b0;
         out_instu <= 32'h0;
         out_pc    <= RESET_PC;
      end else begin
         state     <= state_n;
         pc        <= pc_n;
         drop      <= drop_n;
         out_valid <= out_valid_n;
         out_instu <= out_instu_n;
         out_pc    <= out_pc_n;
      end
   end
   always_comb begin
      state_n     = state;
      pc_n        = pc;
      drop_n      = drop;
      out_valid_n = out_valid;
      out_instu_n = out_instu;
      out_pc_n    = out_pc;
      case (state)
         REQ: if (imem_req_valid && imem_req_ready) begin
            state_n = WAIT;
            // a redirect while the request is accepted makes that fetch stale
            drop_n  = redirect_valid;
         end
         WAIT: if (imem_resp_valid) begin
            state_n = REQ;
            drop_n  = 1'b0;
            if (!drop && !redirect_valid) begin
               state_n     = HOLD;
               out_valid_n = 1'b1;
               out_instu_n = imem_resp_data;
               out_pc_n    = pc;
               pc_n        = pc + PC_WIDTH'(4);
            end
         end else if (redirect_valid) drop_n = 1'b1;
         HOLD: if (out_ready || redirect_valid) begin
            state_n     = REQ;
            out_valid_n = 1'b0;
         end
         default: state_n = REQ;
      endcase
      // redirect wins over every other pc update
      if (redirect_valid) pc_n = redirect_pc & ~PC_WIDTH'(3);
   end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench with a transaction-level reference model for fetch_unit.
module tb_fetch_unit;
   localparam logic [63:0] RST_PC = 64'h8000_0000;
   logic clk = 1'b0;
   logic reset, imem_req_valid, imem_req_ready, imem_resp_valid, out_valid, out_ready, redirect_valid;
   logic [63:0] imem_req_addr, out_pc, redirect_pc;
   logic [31:0] imem_resp_data, out_instu;
   fetch_unit dut (
      .clk(clk), .reset(reset),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_instu(out_instu), .out_pc(out_pc),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );
   always #5 clk = ~clk;
   int vectors = 0, errs = 0;
   // stimulus knobs
   bit g_rst = 1'b0, g_rv = 1'b0, g_ordy = 1'b1, g_rdy = 1'b1;
   logic [63:0] g_rpc = '0;
   int lat = 1;
   // reference model: fetch pointer, one outstanding fetch (maybe stale), one held instruction
   logic [63:0] m_pc = RST_PC, m_opc = RST_PC;
   logic [31:0] m_ins = '0;
   bit m_inflight = 0, m_drop = 0, m_have = 0, m_reqv;
   // memory emulation
   bit pending = 0;
   int pend_cnt = 0;
   logic [63:0] pend_addr = '0;
   // observed DUT handshakes
   logic [63:0] req_log[$], got_pc[$], got_ins[$];
   function automatic logic [31:0] mem(input logic [63:0] a);
      return a[31:0] ^ 32'h1357_9BDF;
   endfunction
   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
      end
   endtask
   task automatic pin(input string n, input logic [63:0] q[$], input int idx, input logic [63:0] exp);
      if (idx < q.size()) chk(n, q[idx], exp);
      else begin
         vectors++;
         errs++;
         $display("FAIL %s: entry %0d missing (only %0d) expected %h", n, idx, q.size(), exp);
      end
   endtask
   task automatic cyc();
      bit resp;
      reset = g_rst; redirect_valid = g_rv; redirect_pc = g_rpc;
      out_ready = g_ordy; imem_req_ready = g_rdy;
      resp = pending && pend_cnt == 1;
      imem_resp_valid = resp;
      imem_resp_data = resp ? mem(pend_addr) : 32'hDEAD_BEEF;
      #1;
      m_reqv = g_rst && !m_inflight && !m_have;
      chk("req_valid", {63'b0, imem_req_valid}, {63'b0, m_reqv});
      if (m_reqv) chk("req_addr", imem_req_addr, m_pc);
      chk("out_valid", {63'b0, out_valid}, {63'b0, m_have});
      chk("out_instu", {32'b0, out_instu}, {32'b0, m_ins});
      chk("out_pc", out_pc, m_opc);
      if (imem_req_valid && imem_req_ready) req_log.push_back(imem_req_addr);
      if (out_valid && out_ready && !redirect_valid) begin
         got_pc.push_back(out_pc);
         got_ins.push_back({32'b0, out_instu});
      end
      @(posedge clk);
      if (!g_rst) begin
         m_pc = RST_PC; m_opc = RST_PC; m_ins = '0;
         m_inflight = 0; m_drop = 0; m_have = 0; pending = 0;
      end else begin
         if (m_have) begin
            if (g_rv || g_ordy) m_have = 0;
         end else if (!m_inflight) begin
            if (g_rdy) begin
               m_inflight = 1; m_drop = g_rv;
               pending = 1; pend_cnt = lat; pend_addr = m_pc;
            end
         end else if (resp) begin
            pending = 0; m_inflight = 0;
            if (!(m_drop || g_rv)) begin
               m_have = 1; m_ins = imem_resp_data; m_opc = m_pc; m_pc = m_pc + 64'd4;
            end
            m_drop = 0;
         end else begin
            if (g_rv) m_drop = 1;
            if (pending) pend_cnt--;
         end
         if (g_rv) m_pc = {g_rpc[63:2], 2'b00};
      end
      g_rv = 0;
      @(negedge clk);
   endtask
   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask
   task automatic redirect(input logic [63:0] a);
      g_rv = 1; g_rpc = a;
      cyc();
   endtask
   initial begin
      int n0, g0, i;
      @(negedge clk);
      // reset held, then straight-line fetch with 1-cycle memory
      run(3);
      g_rst = 1;
      run(9);
      pin("t1_req0", req_log, 0, 64'h8000_0000);
      pin("t1_req1", req_log, 1, 64'h8000_0004);
      pin("t1_req2", req_log, 2, 64'h8000_0008);
      pin("t1_pc0", got_pc, 0, 64'h8000_0000);
      pin("t1_pc2", got_pc, 2, 64'h8000_0008);
      pin("t1_ins0", got_ins, 0, 64'h9357_9BDF);
      pin("t1_ins1", got_ins, 1, 64'h9357_9BDB);
      // backpressure in HOLD
      n0 = req_log.size(); g0 = got_pc.size();
      g_ordy = 0;
      for (i = 0; i < 10 && !m_have; i++) cyc();
      chk("t2_reach_hold", {63'b0, out_valid}, 64'd1);
      run(5);
      chk("t2_no_consume", 64'(got_pc.size()), 64'(g0));
      g_ordy = 1;
      run(4);
      pin("t2_held_req", req_log, n0, 64'h8000_000C);
      pin("t2_next_req", req_log, n0 + 1, 64'h8000_0010);
      pin("t2_held_pc", got_pc, g0, 64'h8000_000C);
      // redirect while waiting for a slow response
      lat = 3;
      for (i = 0; i < 12 && !(pending && pend_cnt == 3); i++) cyc();
      chk("t3_reach_wait", {63'b0, imem_req_valid}, 64'd0);
      n0 = req_log.size(); g0 = got_pc.size();
      redirect(64'h8000_0103);
      run(10);
      pin("t3_req", req_log, n0, 64'h8000_0100);
      pin("t3_pc", got_pc, g0, 64'h8000_0100);
      pin("t3_ins", got_ins, g0, 64'h9357_9ADF);
      // redirect in the same cycle the response arrives
      lat = 2;
      for (i = 0; i < 12 && !(pending && pend_cnt == 1); i++) cyc();
      n0 = req_log.size(); g0 = got_pc.size();
      redirect(64'h8000_0202);
      run(8);
      pin("t4_req", req_log, n0, 64'h8000_0200);
      pin("t4_pc", got_pc, g0, 64'h8000_0200);
      // redirect in HOLD with out_ready high
      lat = 1;
      for (i = 0; i < 12 && !m_have; i++) cyc();
      n0 = req_log.size(); g0 = got_pc.size();
      redirect(64'h8000_0300);
      chk("t5_flush", {63'b0, out_valid}, 64'd0);
      run(4);
      pin("t5_req", req_log, n0, 64'h8000_0300);
      pin("t5_pc", got_pc, g0, 64'h8000_0300);
      // fetch at the top of the address space wraps to zero
      g_rdy = 0;
      for (i = 0; i < 12 && (m_inflight || m_have); i++) cyc();
      n0 = req_log.size(); g0 = got_pc.size();
      redirect(64'hFFFF_FFFF_FFFF_FFFF);
      g_rdy = 1;
      run(6);
      pin("t6_req", req_log, n0, 64'hFFFF_FFFF_FFFF_FFFC);
      pin("t6_wrap", req_log, n0 + 1, 64'h0);
      pin("t6_pc", got_pc, g0, 64'hFFFF_FFFF_FFFF_FFFC);
      pin("t6_ins", got_ins, g0, 64'hECA8_6423);
      // reset while a fetch is outstanding
      lat = 3;
      for (i = 0; i < 12 && !(pending && pend_cnt == 3); i++) cyc();
      n0 = req_log.size();
      g_rst = 0;
      run(2);
      chk("t7_rst_valid", {63'b0, out_valid}, 64'd0);
      chk("t7_rst_pc", out_pc, RST_PC);
      g_rst = 1;
      run(6);
      pin("t7_req", req_log, n0, RST_PC);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
